// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Address generator that sits in front of a 3-to-8 one-hot decoder. It walks
//   a 3-bit slot address through the slots enabled in an 8-bit mask, cyclically.
//   Each slot is held valid for DWELL cycles, then blanked for BLANK_CYC cycles
//   so that two decoder lines are never active at the same time.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   en     in   run request, sampled in IDLE and on the last blank cycle
//   mask   in   [7:0] slot enables, bit i set = slot i is visited
//   A      out  [2:0] current slot address (decoder input)
//   valid  out  high while A is a live selection (decoder enable)
//   wrap   out  one-cycle pulse on the first valid cycle of each frame
module scan_sequencer #(
  parameter int DWELL     = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] mask,
  output logic [2:0] A,
  output logic       valid,
  output logic       wrap
);

  // One counter serves both the dwell and the blank phase, so it is sized for
  // the longer of the two. It only ever counts up to (length - 1).
  localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    a_q;
  logic          valid_q;
  logic          wrap_q;

  logic [2:0]  lowest_idx;
  logic [15:0] mask_dbl;
  logic [7:0]  mask_rot;
  logic [2:0]  step;
  logic [2:0]  next_idx;

  // Rotate the mask so that bit j corresponds to slot (A + 1 + j) mod 8.
  // The lowest set bit of the rotated mask is then the next slot strictly
  // after A in cyclic order; j = 7 lands back on A itself (single-bit mask).
  assign mask_dbl = {mask, mask} >> (4'(a_q) + 4'd1);
  assign mask_rot = mask_dbl[7:0];

  always_comb begin
    lowest_idx = 3'd0;
    step       = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (mask[j]) begin
        lowest_idx = 3'(j);
      end
      if (mask_rot[j]) begin
        step = 3'(j);
      end
    end
    next_idx = a_q + 3'd1 + step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 3'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
          cnt_q   <= '0;
          if (en && (mask != 8'd0)) begin
            // Starting from idle always begins a new frame.
            state_q <= ACTIVE;
            a_q     <= lowest_idx;
            valid_q <= 1'b1;
            wrap_q  <= 1'b1;
          end
        end

        ACTIVE: begin
          // en and mask are deliberately ignored here: a slot always runs
          // its full dwell.
          wrap_q <= 1'b0;
          if (cnt_q == DWELL_LAST) begin
            state_q <= BLANK;
            valid_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        BLANK: begin
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
          if (cnt_q == BLANK_LAST) begin
            cnt_q <= '0;
            if (en && (mask != 8'd0)) begin
              state_q <= ACTIVE;
              a_q     <= next_idx;
              valid_q <= 1'b1;
              // Search wrapped past slot 7 (or stayed put): new frame.
              wrap_q  <= (next_idx <= a_q);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A     = a_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  localparam int DWELL     = 4;
  localparam int BLANK_CYC = 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [2:0] A;
  logic       valid;
  logic       wrap;

  int total;
  int bad;

  scan_sequencer #(
    .DWELL    (DWELL),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mask (mask),
    .A    (A),
    .valid(valid),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock edge: inputs present at the edge, outputs expected
  // just after it.
  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] mask;
    logic [2:0] a;
    logic       v;
    logic       w;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [7:0] m,
                     input logic [2:0] a, input logic v, input logic w);
    vec_t t;
    t.rst = r; t.en = e; t.mask = m; t.a = a; t.v = v; t.w = w;
    vecs.push_back(t);
  endtask

  // A complete slot: DWELL valid cycles (wrap only on the first) then
  // BLANK_CYC blank cycles. The first record carries the inputs sampled on
  // the edge that launches the slot.
  task automatic add_slot(input logic [2:0] a, input logic w,
                          input logic e_first, input logic e_rest,
                          input logic [7:0] m_first, input logic [7:0] m_rest);
    for (int i = 0; i < DWELL; i++) begin
      add(1'b0, (i == 0) ? e_first : e_rest, (i == 0) ? m_first : m_rest,
          a, 1'b1, (i == 0) ? w : 1'b0);
    end
    for (int i = 0; i < BLANK_CYC; i++) begin
      add(1'b0, e_rest, m_rest, a, 1'b0, 1'b0);
    end
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int cycles;
    int vcount;
    bit seen;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    mask  = 8'h00;

    // Reset, reset dominating en/mask, idle holds without en or without mask.
    add(1, 0, 8'h00, 0, 0, 0);
    add(1, 1, 8'hFF, 0, 0, 0);
    add(0, 0, 8'hFF, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0);

    // Full mask: 0..7 then frame wrap back to 0.
    for (int s = 0; s < 8; s++) add_slot(3'(s), (s == 0), 1, 1, 8'hFF, 8'hFF);
    add_slot(0, 1, 1, 1, 8'hFF, 8'hFF);
    add_slot(1, 0, 1, 1, 8'hFF, 8'hFF);

    // Sparse mask 10100100: 2,5,7 repeating, wrap on return to 2.
    add_slot(2, 0, 1, 1, 8'hA4, 8'hA4);
    add_slot(5, 0, 1, 1, 8'hA4, 8'hA4);
    add_slot(7, 0, 1, 1, 8'hA4, 8'hA4);
    add_slot(2, 1, 1, 1, 8'hA4, 8'hA4);
    add_slot(5, 0, 1, 1, 8'hA4, 8'hA4);
    add_slot(7, 0, 1, 1, 8'hA4, 8'hA4);
    add_slot(2, 1, 1, 1, 8'hA4, 8'hA4);

    // Single-bit mask: 2 -> 4 is forward, then 4 -> 4 wraps every slot.
    add_slot(4, 0, 1, 1, 8'h10, 8'h10);
    add_slot(4, 1, 1, 1, 8'h10, 8'h10);
    add_slot(4, 1, 1, 1, 8'h10, 8'h10);

    // Mask {1,3,6}: 4 -> 6, 6 -> 1 (wrap), 1 -> 3 with en dropped mid-dwell.
    add_slot(6, 0, 1, 1, 8'h4A, 8'h4A);
    add_slot(1, 1, 1, 1, 8'h4A, 8'h4A);
    add_slot(3, 0, 1, 0, 8'h4A, 8'h4A);
    add(0, 0, 8'h4A, 3, 0, 0);
    add(0, 0, 8'h4A, 3, 0, 0);

    // Re-assert en: lowest bit 1 with wrap; mask cleared mid-slot.
    add_slot(1, 1, 1, 1, 8'h4A, 8'h00);
    add(0, 1, 8'h00, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0);
    add(0, 1, 8'h00, 1, 0, 0);

    // Mask restored to slot 6 only; reset during its third valid cycle.
    add(0, 1, 8'h40, 6, 1, 1);
    add(0, 1, 8'h40, 6, 1, 0);
    add(0, 1, 8'h40, 6, 1, 0);
    add(1, 1, 8'h40, 0, 0, 0);

    // Resume after reset at lowest bit of {5,6}.
    add_slot(5, 1, 1, 1, 8'h60, 8'h60);
    add_slot(6, 0, 1, 1, 8'h60, 8'h60);
    add_slot(5, 1, 1, 1, 8'h60, 8'h60);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      mask = vecs[i].mask;
      @(posedge clk);
      #1;
      $display("vec %0d rst=%0b en=%0b mask=%02h -> A=%0d valid=%0b wrap=%0b",
               i, vecs[i].rst, vecs[i].en, vecs[i].mask, A, valid, wrap);
      check("A", i, 8'(A), 8'(vecs[i].a));
      check("valid", i, 8'(valid), 8'(vecs[i].v));
      check("wrap", i, 8'(wrap), 8'(vecs[i].w));
    end

    // Frame period with full mask: wrap-to-wrap distance and valid count.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    en   = 1'b1;
    mask = 8'hFF;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (wrap) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL first_wrap timeout actual=none required=pulse");
    end else begin
      cycles = 0;
      vcount = 1;
      seen   = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(posedge clk);
        #1;
        cycles++;
        if (wrap) seen = 1;
        else if (valid) vcount++;
      end
      $display("frame: wrap period=%0d valid cycles=%0d", cycles, vcount);
      total++;
      if (!seen || cycles != 8 * (DWELL + BLANK_CYC)) begin
        bad++;
        $display("FAIL frame_period actual=%0d required=%0d", cycles,
                 8 * (DWELL + BLANK_CYC));
      end
      total++;
      if (vcount != 8 * DWELL) begin
        bad++;
        $display("FAIL frame_valid_count actual=%0d required=%0d", vcount, 8 * DWELL);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
